// File: rtl/scroll_step_ctrl.sv
// scroll_step_ctrl: turns rising edges of one counter16 tap bit into scroll ticks and walks a
// character-window offset through a message of length msg_len, pulsing step/wrap as it goes.
// Optional feature macro: SCROLL_HOLD_EN -- after a wrap, dwell at offset 0 for HOLD_TICKS ticks.
module scroll_step_ctrl #(
  parameter int unsigned TAP_BIT    = 15,
  parameter int unsigned LEN_W      = 6,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      cnt_q,
  input  logic             en,
  input  logic             clr,
  input  logic [LEN_W-1:0] msg_len,
  output logic [LEN_W-1:0] offset,
  output logic             step,
  output logic             wrap,
  output logic             holding
);

`ifdef SCROLL_HOLD_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StHold = 2'd2} state_e;

  localparam int unsigned HoldW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_TICKS);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1} state_e;

  // Dwell length only matters when the hold feature is built in.
  localparam int unsigned unused_hold_ticks = HOLD_TICKS;
`endif

  state_e           state_q, state_d;
  logic             tap_q;
  logic [LEN_W-1:0] offset_q, offset_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic [LEN_W-1:0] last_idx;
  logic             unused_cnt;

  // Only the tap bit of the count is consumed.
  assign unused_cnt = ^cnt_q;

  assign tick     = cnt_q[TAP_BIT] & ~tap_q;
  assign last_idx = msg_len - LEN_W'(1);

  // State, offset, pulse and tap-delay registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      tap_q    <= 1'b0;
      offset_q <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= cnt_q[TAP_BIT];
      offset_q <= offset_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef SCROLL_HOLD_EN
  // Dwell counter for the post-wrap hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  // Next-state logic; priority is en=0, then clr, then tick.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
`ifdef SCROLL_HOLD_EN
    hold_cnt_d = hold_cnt_q;
`endif
    if (!en) begin
      state_d = StIdle;
`ifdef SCROLL_HOLD_EN
      hold_cnt_d = '0;
`endif
    end else if (clr) begin
      state_d  = StRun;
      offset_d = '0;
`ifdef SCROLL_HOLD_EN
      hold_cnt_d = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // Ticks seen while idle are dropped; scrolling starts on the next one.
          state_d = StRun;
        end
        StRun: begin
          if (tick) begin
            if (msg_len <= LEN_W'(1)) begin
              offset_d = '0;
            end else if (offset_q < last_idx) begin
              offset_d = offset_q + LEN_W'(1);
              step_d   = 1'b1;
            end else begin
              // >= also catches a length that shrank below the current offset.
              offset_d = '0;
              step_d   = 1'b1;
              wrap_d   = 1'b1;
`ifdef SCROLL_HOLD_EN
              state_d    = StHold;
              hold_cnt_d = HoldLoad;
`endif
            end
          end
        end
`ifdef SCROLL_HOLD_EN
        StHold: begin
          if (tick) begin
            if (hold_cnt_q <= HoldW'(1)) begin
              state_d    = StRun;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q - HoldW'(1);
            end
          end
        end
`endif
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign offset = offset_q;
  assign step   = step_q;
  assign wrap   = wrap_q;
`ifdef SCROLL_HOLD_EN
  assign holding = (state_q == StHold);
`else
  assign holding = 1'b0;
`endif

endmodule

// File: tb/tb_scroll_step_ctrl.sv
// Bench for scroll_step_ctrl with TAP_BIT=2 (one tick every 8 clocks), LEN_W=6, HOLD_TICKS=4.
// Follows SCROLL_HOLD_EN the same way the design does.
module tb_scroll_step_ctrl;
  localparam int unsigned LenW = 6;
`ifdef SCROLL_HOLD_EN
  localparam logic HoldEn = 1'b1;
`else
  localparam logic HoldEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [15:0]     cnt_q = 16'd0;
  logic            en = 1'b0;
  logic            clr = 1'b0;
  logic [LenW-1:0] msg_len = 6'd4;
  logic [LenW-1:0] offset;
  logic            step;
  logic            wrap;
  logic            holding;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic            en;
    logic            clr;
    logic [LenW-1:0] len;
    logic [LenW-1:0] off;
    logic            st;
    logic            wr;
    logic            ho;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  // Stand-in for counter16: free-running count.
  always @(posedge clk) cnt_q <= cnt_q + 16'd1;

  scroll_step_ctrl #(
    .TAP_BIT   (2),
    .LEN_W     (LenW),
    .HOLD_TICKS(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt_q  (cnt_q),
    .en     (en),
    .clr    (clr),
    .msg_len(msg_len),
    .offset (offset),
    .step   (step),
    .wrap   (wrap),
    .holding(holding)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare all outputs packed as {offset, step, wrap, holding}.
  task automatic check_out(input string name, input int off, input logic st, input logic wr,
                           input logic ho);
    check(name, {23'd0, offset, step, wrap, holding}, {23'd0, 6'(off), st, wr, ho});
  endtask

  function automatic void add(input logic e, input logic c, input int len, input int off,
                              input logic st, input logic wr, input logic ho);
    vec_t v;
    v.en  = e;
    v.clr = c;
    v.len = 6'(len);
    v.off = 6'(off);
    v.st  = st;
    v.wr  = wr;
    v.ho  = ho;
    vecs.push_back(v);
  endfunction

  // Run up to the cycle whose closing edge consumes a tap rising edge (count ends in 3'b100),
  // checking step/wrap stay low meanwhile; optionally pulse clr on that cycle; return at the
  // negedge just after that edge, where the tick's result is visible.
  task automatic next_tick(input logic do_clr);
    int n = 0;
    @(negedge clk);
    while (cnt_q[2:0] != 3'd4 && n < 20) begin
      check("quiet", {30'd0, step, wrap}, 32'd0);
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL tick_wait: got no tick within %0d cycles expected one within 8", n);
    end
    check("quiet", {30'd0, step, wrap}, 32'd0);
    clr = do_clr;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    // Expected results, one entry per tick.
    // Run through a 4-char message with wrap.
    add(1, 0, 4, 1, 1, 0, 0);
    add(1, 0, 4, 2, 1, 0, 0);
    add(1, 0, 4, 3, 1, 0, 0);
    add(1, 0, 4, 0, 1, 1, HoldEn);
`ifdef SCROLL_HOLD_EN
    for (int i = 0; i < 4; i++) add(1, 0, 4, 0, 0, 0, (i < 3));
`endif
    add(1, 0, 4, 1, 1, 0, 0);
    // Grow to 8 and reach offset 6, then shrink to 3.
    for (int i = 2; i <= 6; i++) add(1, 0, 8, i, 1, 0, 0);
    add(1, 0, 3, 0, 1, 1, HoldEn);
    for (int i = 0; i < 10; i++) add(1, 0, 1, 0, 0, 0, HoldEn && (i < 3));
    // Enable / clear controls.
    add(1, 0, 4, 1, 1, 0, 0);
    add(1, 0, 4, 2, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 4, 2, 0, 0, 0);
    add(1, 0, 4, 3, 1, 0, 0);
    add(1, 1, 4, 0, 0, 0, 0);
    add(1, 0, 4, 1, 1, 0, 0);
    // Zero-length message behaves like length 1.
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 4, 1, 1, 0, 0);

    // Reset held while the count runs: outputs must stay at reset values.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_out($sformatf("reset_hold[%0d]", i), 0, 0, 0, 0);
    end
    rst_n   = 1'b1;
    en      = 1'b1;
    msg_len = 6'd4;

    foreach (vecs[i]) begin
      en      = vecs[i].en;
      msg_len = vecs[i].len;
      next_tick(vecs[i].clr);
      check_out($sformatf("vec[%0d]", i), vecs[i].off, vecs[i].st, vecs[i].wr, vecs[i].ho);
    end

    // Reset in the middle of operation (during HOLD when that is built in).
    en      = 1'b1;
    msg_len = 6'd4;
    next_tick(1'b0);
    check_out("pre_rst_a", 2, 1, 0, 0);
    next_tick(1'b0);
    check_out("pre_rst_b", 3, 1, 0, 0);
`ifdef SCROLL_HOLD_EN
    next_tick(1'b0);
    check_out("pre_rst_wrap", 0, 1, 1, 1);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_out("mid_reset", 0, 0, 0, 0);
    next_tick(1'b0);
    check_out("post_reset_tick", 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
